video_ram_ctrl: RTL
===================

VIDEO_RAM_CTRL -- requirements
Module: video_ram_ctrl

Interface
REQ-001 Parameter ADDR_W, default 11, video word address width (2048 words = 64 x 32 screen).
REQ-002 Parameter RESET_ATTR, default 8'h0E, attribute byte loaded by fill when FILL_ATTR is unused (VRAM_CLEAR_EN absent: unused).
REQ-003 Port CLK  input  1  system clock; all logic on its negative edge.
REQ-004 Port RESET  input  1  reset, asynchronous and active-high.
REQ-005 Port VID_ADDRESS  input  ADDR_W  word address from the display generator.
REQ-006 Port VID_ENABLE  input  1  display read strobe, one cycle wide.
REQ-007 Port VID_DATA  output  16  {attribute, character} word to the display generator.
REQ-008 Port CPU_ADDRESS  input  ADDR_W+1  bits [ADDR_W:1] word address; bit 0: 0 = character byte, 1 = attribute byte.
REQ-009 Port CPU_DATA_IN  input  8  CPU write byte.
REQ-010 Port CPU_WE / CPU_RE  input  1 each  CPU write / read request, level, held until CPU_READY.
REQ-011 Port CPU_DATA_OUT  output  8  CPU read byte.
REQ-012 Port CPU_READY  output  1  one-cycle completion pulse.
REQ-013 Ports FILL_START  input  1 | FILL_CHAR, FILL_ATTR  input  8 each | FILL_BUSY  output  1  hardware screen fill.

Function
REQ-014 Internal 2^ADDR_W x 16 RAM, single port, byte write enables, synchronous read, 1-cycle latency.
REQ-015 Per-cycle port priority: video > CPU > fill; exactly one RAM access per cycle.
REQ-016 VID_ENABLE at cycle T -> RAM read at T; VID_DATA updates at T+1 and holds until the next video read completes.
REQ-017 CPU request granted in the first cycle without VID_ENABLE; write updates only the selected byte lane.
REQ-018 CPU_READY pulses one cycle after grant; for reads CPU_DATA_OUT carries the selected byte in that cycle and holds afterwards.
REQ-019 CPU latency: 1 cycle without collision, 2 cycles when colliding with VID_ENABLE.
REQ-020 CPU_WE and CPU_RE both high: write performed, read ignored.
REQ-021 No new CPU grant in the cycle CPU_READY is high; requests must drop after CPU_READY, otherwise they are serviced again.
REQ-022 State machine IDLE -> CPU_DONE on CPU grant -> IDLE; IDLE -> FILL on FILL_START; FILL -> IDLE after word 2^ADDR_W-1 written.
REQ-023 In FILL: one word {FILL_ATTR, FILL_CHAR} written per cycle with no video or CPU access; a CPU request preempts for one access and fill resumes at the same address.
REQ-024 Fill address counter starts at 0, increments only on its own writes, does not wrap; FILL_BUSY high from cycle after FILL_START until cycle after last write.
REQ-025 FILL_START while FILL_BUSY ignored; FILL_CHAR/FILL_ATTR sampled once at start.

Reset
REQ-026 RESET forces IDLE, VID_DATA=16'h0000, CPU_DATA_OUT=8'h00, CPU_READY=0, FILL_BUSY=0, fill counter 0; an in-progress fill or CPU access is aborted; RAM contents are not cleared.

Configuration
REQ-027 Macro VRAM_CLEAR_EN defined: fill engine, FILL state and FILL_* ports present, and one automatic fill with {RESET_ATTR, 8'h20} starts in the first cycle after RESET deasserts.
REQ-028 Macro VRAM_CLEAR_EN undefined: no fill logic, FILL_START ignored, FILL_BUSY tied 0, no post-reset fill.

Structure
REQ-029 Shared package vram_pkg holds the state enum (IDLE, CPU_DONE, FILL), ADDR_W default, screen geometry constants (64 columns, 32 rows), and the space code 8'h20.
REQ-030 Sub-module vram_bytewe_ram: 16-bit byte-write synchronous RAM, instantiated once.

Verification
REQ-031 CPU writes 8'h41 to CPU_ADDRESS 12'h002, then 8'h1A to 12'h003; video read of word 1 -> VID_DATA=16'h1A41 one cycle after VID_ENABLE.
REQ-032 CPU_RE raised in the same cycle as VID_ENABLE -> video data returned at T+1, CPU_READY at T+2 with correct byte.
REQ-033 FILL_START with FILL_CHAR=8'h20 and FILL_ATTR=8'h0E -> FILL_BUSY high 2048 cycles with no contention; all words read back 16'h0E20.
REQ-034 CPU write to 12'h100 mid-fill -> fill pauses one cycle, both writes land, FILL_BUSY duration extended by exactly 1.
REQ-035 RESET asserted mid-fill -> FILL_BUSY and outputs at reset values immediately; with VRAM_CLEAR_EN, new fill starts after release.
REQ-036 CPU_WE and CPU_RE both high -> byte written, single CPU_READY pulse, CPU_DATA_OUT unchanged.

Source files
------------

// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - shared state encoding, geometry and codes for the video RAM controller
package vram_pkg;

  localparam int SCREEN_COLS = 64;
  localparam int SCREEN_ROWS = 32;
  localparam int VRAM_ADDR_W = $clog2(SCREEN_COLS * SCREEN_ROWS);

  localparam logic [7:0] SPACE_CODE = 8'h20;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CPU_DONE = 2'd1,
    FILL     = 2'd2
  } vram_state_e;

  // Byte-lane write enable for a CPU byte access: bit 0 of the byte address
  // selects the attribute (high) or character (low) half of the word.
  function automatic logic [1:0] lane_we(input logic hi);
    return hi ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/vram_bytewe_ram.sv
// rtl/vram_bytewe_ram.sv - single-port 16-bit RAM with byte write enables, 1-cycle read
// Ports: clk (negative-edge), addr, we[1:0] (byte lanes), wdata, rdata (registered, read-first)
module vram_bytewe_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        we,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [0:(1 << ADDR_W) - 1];
  logic [15:0] rdata_q;

  always_ff @(negedge clk) begin
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/video_ram_ctrl.sv
// rtl/video_ram_ctrl.sv - video RAM arbiter: display reads, CPU byte access, hardware screen fill
// Ports: CLK (negative-edge), RESET (async, active-high)
//        VID_ADDRESS/VID_ENABLE -> VID_DATA      display read, data one cycle later, held
//        CPU_ADDRESS/CPU_DATA_IN/CPU_WE/CPU_RE -> CPU_DATA_OUT/CPU_READY   byte access
//        FILL_START/FILL_CHAR/FILL_ATTR -> FILL_BUSY   screen fill
// Macro VRAM_CLEAR_EN: enables the fill engine and an automatic clear after reset.
module video_ram_ctrl
  import vram_pkg::*;
#(
  parameter int         ADDR_W     = VRAM_ADDR_W,
  parameter logic [7:0] RESET_ATTR = 8'h0E
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [ADDR_W-1:0] VID_ADDRESS,
  input  logic              VID_ENABLE,
  output logic [15:0]       VID_DATA,
  input  logic [ADDR_W:0]   CPU_ADDRESS,
  input  logic [7:0]        CPU_DATA_IN,
  input  logic              CPU_WE,
  input  logic              CPU_RE,
  output logic [7:0]        CPU_DATA_OUT,
  output logic              CPU_READY,
  input  logic              FILL_START,
  input  logic [7:0]        FILL_CHAR,
  input  logic [7:0]        FILL_ATTR,
  output logic              FILL_BUSY
);

  vram_state_e       state_q, state_d;
  logic              vid_rd_q, vid_rd_d;
  logic [15:0]       vid_data_q, vid_data_d;
  logic              cpu_ready_q, cpu_ready_d;
  logic              cpu_rd_q, cpu_rd_d;
  logic              cpu_hi_q, cpu_hi_d;
  logic [7:0]        cpu_data_q, cpu_data_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;
  logic [15:0]       fill_word_q, fill_word_d;

  logic              cpu_grant;
  logic              fill_wr;
  logic              fill_go;
  logic [15:0]       fill_start_word;
  logic [ADDR_W-1:0] ram_addr;
  logic [1:0]        ram_we;
  logic [15:0]       ram_wdata;
  logic [15:0]       ram_rdata;
  logic [7:0]        cpu_rd_byte;

`ifdef VRAM_CLEAR_EN
  // Set by reset so the first cycle after release launches a screen clear.
  logic auto_fill_q, auto_fill_d;

  assign auto_fill_d     = 1'b0;
  assign fill_go         = (FILL_START || auto_fill_q) && (state_q != FILL);
  assign fill_start_word = auto_fill_q ? {RESET_ATTR, SPACE_CODE} : {FILL_ATTR, FILL_CHAR};

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) auto_fill_q <= 1'b1;
    else       auto_fill_q <= auto_fill_d;
  end
`else
  logic unused_fill;

  assign fill_go         = 1'b0;
  assign fill_start_word = 16'h0000;
  assign unused_fill     = ^{FILL_START, FILL_CHAR, FILL_ATTR, RESET_ATTR, SPACE_CODE};
`endif

  // One RAM access per cycle: video, else CPU, else fill.
  always_comb begin
    cpu_grant = (CPU_WE || CPU_RE) && !VID_ENABLE && !cpu_ready_q;
    fill_wr   = (state_q == FILL) && !VID_ENABLE && !cpu_grant;
    ram_addr  = fill_addr_q;
    ram_we    = 2'b00;
    ram_wdata = fill_word_q;
    if (VID_ENABLE) begin
      ram_addr = VID_ADDRESS;
    end else if (cpu_grant) begin
      ram_addr  = CPU_ADDRESS[ADDR_W:1];
      ram_wdata = {CPU_DATA_IN, CPU_DATA_IN};
      if (CPU_WE) ram_we = lane_we(CPU_ADDRESS[0]);
    end else if (fill_wr) begin
      ram_we = 2'b11;
    end
  end

  vram_bytewe_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (CLK),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign cpu_rd_byte = cpu_hi_q ? ram_rdata[15:8] : ram_rdata[7:0];

  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_word_d = fill_word_q;
    vid_rd_d    = VID_ENABLE;
    vid_data_d  = vid_rd_q ? ram_rdata : vid_data_q;
    cpu_ready_d = cpu_grant;
    // A simultaneous write wins; the read half of the request is dropped.
    cpu_rd_d    = cpu_grant && CPU_RE && !CPU_WE;
    cpu_hi_d    = cpu_grant ? CPU_ADDRESS[0] : cpu_hi_q;
    cpu_data_d  = cpu_rd_q ? cpu_rd_byte : cpu_data_q;
    case (state_q)
      IDLE, CPU_DONE: begin
        if (fill_go) begin
          state_d     = FILL;
          fill_addr_d = '0;
          fill_word_d = fill_start_word;
        end else if (cpu_grant) begin
          state_d = CPU_DONE;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        // Address only advances on the fill's own writes, so a preempting
        // access makes the fill resume at the same word.
        if (fill_wr) begin
          if (&fill_addr_q) state_d = IDLE;
          else              fill_addr_d = fill_addr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      vid_rd_q    <= 1'b0;
      vid_data_q  <= 16'h0000;
      cpu_ready_q <= 1'b0;
      cpu_rd_q    <= 1'b0;
      cpu_hi_q    <= 1'b0;
      cpu_data_q  <= 8'h00;
      fill_addr_q <= '0;
      fill_word_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      vid_rd_q    <= vid_rd_d;
      vid_data_q  <= vid_data_d;
      cpu_ready_q <= cpu_ready_d;
      cpu_rd_q    <= cpu_rd_d;
      cpu_hi_q    <= cpu_hi_d;
      cpu_data_q  <= cpu_data_d;
      fill_addr_q <= fill_addr_d;
      fill_word_q <= fill_word_d;
    end
  end

  // Fresh RAM data is forwarded in the completion cycle, then held.
  assign VID_DATA     = vid_rd_q ? ram_rdata : vid_data_q;
  assign CPU_DATA_OUT = cpu_rd_q ? cpu_rd_byte : cpu_data_q;
  assign CPU_READY    = cpu_ready_q;
  assign FILL_BUSY    = (state_q == FILL);

endmodule
